timer_counter: RTL and testbench

//  Memory-mapped down-counting timer on the bridge device bus of the P7 CPU.

---
 rtl/timer_counter.sv | 185 ++++++++++++++++++
 tb/tb_timer_counter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counting timer with interrupt request.
// Register map (word offset): 0=CTRL {IM,MODE[1:0],EN}, 1=PRESET, 2=COUNT (read-only), 3=reserved.
// Optional build macro TIMER_PRESCALE_EN: the count advances only once every PRESCALE cycles.
module timer_counter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned PRESCALE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int unsigned CTRL_W = 4;
  localparam logic [1:0]  ADDR_CTRL   = 2'd0;
  localparam logic [1:0]  ADDR_PRESET = 2'd1;
  localparam logic [1:0]  ADDR_COUNT  = 2'd2;

  // CTRL field positions
  localparam int unsigned CTRL_EN = 0;
  localparam int unsigned CTRL_IM = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  // Elaboration-time sanity check on the prescale divisor
  if (PRESCALE < 1) begin : g_prescale_chk
    $error("timer_counter: PRESCALE must be >= 1");
  end

  state_e             state_q, state_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [WIDTH-1:0]   preset_q, preset_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic               flag_q, flag_d;

  logic               ctrl_wr_c;
  logic               preset_wr_c;
  logic               auto_reload_c;
  logic               tick_c;
  logic               en_clr_c;
  logic               flag_set_c;

  assign ctrl_wr_c     = we && (addr == ADDR_CTRL);
  assign preset_wr_c   = we && (addr == ADDR_PRESET);
  // MODE 1x falls back to one-shot, so only 01 reloads
  assign auto_reload_c = (ctrl_q[2:1] == 2'b01);

`ifdef TIMER_PRESCALE_EN
  localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_q, ps_d;

  assign tick_c = (ps_q == PS_LAST);

  // Prescale counter runs only while staying in CNT; wraps to 0 on each tick
  always_comb begin
    ps_d = '0;
    if ((state_q == ST_CNT) && (state_d == ST_CNT) && !tick_c) begin
      ps_d = ps_q + PS_W'(1);
    end
  end

  // Prescale counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end
`else
  // Without prescaling every CNT cycle is a tick
  assign tick_c = 1'b1;
`endif

  // FSM next-state and count update; raises side-effect strobes for CTRL/flag
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    en_clr_c   = 1'b0;
    flag_set_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_q[CTRL_EN]) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q[CTRL_EN]) begin
          state_d = ST_IDLE;
        end else if (tick_c) begin
          // A count of 0 or 1 both expire here, so P=0 behaves as P=1 and never wraps
          if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
          end else begin
            count_d = '0;
            state_d = ST_INT;
          end
        end
      end
      ST_INT: begin
        flag_set_c = 1'b1;
        if (auto_reload_c) begin
          state_d = ST_LOAD;
        end else begin
          en_clr_c = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Software-visible register updates; a CTRL write overrides the hardware EN clear,
  // while a flag set from INT overrides the clear caused by that same CTRL write
  always_comb begin
    ctrl_d = ctrl_q;
    if (en_clr_c) begin
      ctrl_d[CTRL_EN] = 1'b0;
    end
    if (ctrl_wr_c) begin
      ctrl_d = wdata[CTRL_W-1:0];
    end

    flag_d = flag_q;
    if (ctrl_wr_c) begin
      flag_d = 1'b0;
    end
    if (flag_set_c) begin
      flag_d = 1'b1;
    end

    preset_d = preset_q;
    if (preset_wr_c) begin
      preset_d = WIDTH'(wdata);
    end
  end

  // State and register file
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  // Zero-latency read mux, narrower fields zero-extended
  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_CTRL:   rdata = 32'(ctrl_q);
      ADDR_PRESET: rdata = 32'(preset_q);
      ADDR_COUNT:  rdata = 32'(count_q);
      default:     rdata = '0;
    endcase
  end

  // Interrupt request is the sticky flag gated by the mask bit
  assign irq = flag_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: stimulus pushes expected {rdata, irq} per sampled
// cycle, a negedge monitor pops and compares.
module tb_timer_counter;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;
  localparam logic [1:0] A_RSVD   = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  always #5 clk = ~clk;

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  typedef struct {
    logic [31:0] r;
    logic        i;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  logic mon_v = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: compare the presented outputs against the oldest expectation
  always @(negedge clk) begin
    if (mon_v) begin
      exp_t e;
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_underflow: sample presented with no expectation queued");
      end else begin
        e = sb_q.pop_front();
        if ((rdata !== e.r) || (irq !== e.i)) begin
          n_bad++;
          $display("FAIL %s: got rdata=0x%08h irq=%b, expected rdata=0x%08h irq=%b",
                   e.tag, rdata, irq, e.r, e.i);
        end
      end
    end
  end

  // One bus cycle; optionally queue an expectation sampled mid-cycle
  task automatic cyc(input logic w, input logic [1:0] a, input logic [31:0] d,
                     input logic chk, input logic [31:0] er, input logic ei, input string tag);
    exp_t e;
    we    = w;
    addr  = a;
    wdata = d;
    mon_v = chk;
    if (chk) begin
      e.r   = er;
      e.i   = ei;
      e.tag = tag;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(1'b1, a, d, 1'b0, 32'd0, 1'b0, "");
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] er, input logic ei, input string tag);
    cyc(1'b0, a, 32'd0, 1'b1, er, ei, tag);
  endtask

  task automatic idle();
    cyc(1'b0, A_CTRL, 32'd0, 1'b0, 32'd0, 1'b0, "");
  endtask

  task automatic do_reset();
    we    = 1'b0;
    mon_v = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Assert reset between edges and expect all-zero outputs before any clock edge
  task automatic rst_check(input logic [1:0] a, input string tag);
    exp_t e;
    we    = 1'b0;
    addr  = a;
    wdata = 32'd0;
    reset = 1'b0;
    e.r   = 32'd0;
    e.i   = 1'b0;
    e.tag = tag;
    sb_q.push_back(e);
    mon_v = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    mon_v = 1'b0;
  endtask

  initial begin
    logic [31:0] c3 [9];
    logic        i3 [9];
    c3 = '{32'd2, 32'd1, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd2};
    i3 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    reset = 1'b0;
    we    = 1'b0;
    addr  = A_CTRL;
    wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset state and register access
    rd(A_CTRL,   32'd0, 1'b0, "rst_ctrl");
    rd(A_PRESET, 32'd0, 1'b0, "rst_preset");
    rd(A_COUNT,  32'd0, 1'b0, "rst_count");
    rd(A_RSVD,   32'd0, 1'b0, "rst_rsvd");
    wr(A_COUNT, 32'h0000_0055);
    wr(A_RSVD,  32'h0000_00AA);
    rd(A_COUNT, 32'd0, 1'b0, "count_write_ignored");
    rd(A_RSVD,  32'd0, 1'b0, "rsvd_write_ignored");
    wr(A_CTRL, 32'hFFFF_FFF0);
    rd(A_CTRL, 32'd0, 1'b0, "ctrl_upper_bits_zero");
    wr(A_PRESET, 32'hDEAD_BEEF);
    rd(A_PRESET, 32'hDEAD_BEEF, 1'b0, "preset_full_width");

`ifndef TIMER_PRESCALE_EN
    // Async reset mid-count (count is 7 when reset falls)
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h9);
    idle();
    idle();
    rd(A_COUNT, 32'd10, 1'b0, "t1_count10");
    rd(A_COUNT, 32'd9,  1'b0, "t1_count9");
    rd(A_COUNT, 32'd8,  1'b0, "t1_count8");
    rst_check(A_COUNT, "t1_async_reset_count");
    rd(A_CTRL,   32'd0, 1'b0, "t1_ctrl_cleared");
    rd(A_PRESET, 32'd0, 1'b0, "t1_preset_cleared");
    rd(A_COUNT,  32'd0, 1'b0, "t1_idle_count0");
    rd(A_COUNT,  32'd0, 1'b0, "t1_stays_idle");

    // One-shot with interrupt enabled
    wr(A_PRESET, 32'd3);
    wr(A_CTRL, 32'h9);
    idle();
    idle();
    rd(A_COUNT, 32'd3, 1'b0, "t2_count3");
    rd(A_COUNT, 32'd2, 1'b0, "t2_count2");
    rd(A_COUNT, 32'd1, 1'b0, "t2_count1");
    rd(A_COUNT, 32'd0, 1'b0, "t2_int_state");
    rd(A_COUNT, 32'd0, 1'b1, "t2_irq_set");
    rd(A_CTRL,  32'h8, 1'b1, "t2_en_cleared");
    cyc(1'b1, A_CTRL, 32'h0, 1'b1, 32'h8, 1'b1, "t2_before_ctrl_clear");
    rd(A_CTRL,  32'h0, 1'b0, "t2_irq_dropped");

    // Auto-reload, flag sticky across reloads, then async reset drops irq
    do_reset();
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'hB);
    idle();
    idle();
    for (int i = 0; i < 9; i++) begin
      rd(A_COUNT, c3[i], i3[i], $sformatf("t3_reload_%0d", i));
    end
    rd(A_CTRL, 32'hB, 1'b1, "t3_ctrl_kept");
    rst_check(A_CTRL, "t3_async_reset_irq");

    // Masked expiry
    wr(A_PRESET, 32'd1);
    wr(A_CTRL, 32'h1);
    idle();
    idle();
    rd(A_COUNT, 32'd1, 1'b0, "t4_count1");
    rd(A_COUNT, 32'd0, 1'b0, "t4_int_masked");
    rd(A_CTRL,  32'h0, 1'b0, "t4_en_cleared_masked");
    cyc(1'b1, A_CTRL, 32'h8, 1'b1, 32'h0, 1'b0, "t4_write_im");
    rd(A_CTRL,  32'h8, 1'b0, "t4_irq_stays_low");

    // PRESET write mid-count only affects the next reload
    do_reset();
    wr(A_PRESET, 32'd6);
    wr(A_CTRL, 32'hB);
    idle();
    idle();
    rd(A_COUNT, 32'd6, 1'b0, "t5_count6");
    cyc(1'b1, A_PRESET, 32'd9, 1'b1, 32'd6, 1'b0, "t5_preset_write_at5");
    rd(A_COUNT, 32'd4, 1'b0, "t5_count4");
    rd(A_COUNT, 32'd3, 1'b0, "t5_count3");
    rd(A_COUNT, 32'd2, 1'b0, "t5_count2");
    rd(A_COUNT, 32'd1, 1'b0, "t5_count1");
    rd(A_COUNT, 32'd0, 1'b0, "t5_int");
    rd(A_COUNT, 32'd0, 1'b1, "t5_load");
    rd(A_COUNT, 32'd9, 1'b1, "t5_reload9");
    rd(A_COUNT, 32'd8, 1'b1, "t5_count8");

    // CTRL write during INT: software EN wins, flag still ends set
    do_reset();
    wr(A_PRESET, 32'd1);
    wr(A_CTRL, 32'h9);
    idle();
    idle();
    rd(A_COUNT, 32'd1, 1'b0, "t7_count1");
    cyc(1'b1, A_CTRL, 32'h9, 1'b1, 32'h9, 1'b0, "t7_ctrl_write_in_int");
    rd(A_CTRL,  32'h9, 1'b1, "t7_sw_wins_flag_set");
    rd(A_COUNT, 32'd0, 1'b1, "t7_relaunch_load");
    rd(A_COUNT, 32'd1, 1'b1, "t7_restarted");

    // PRESET=0 expires like PRESET=1
    do_reset();
    wr(A_CTRL, 32'h9);
    idle();
    idle();
    rd(A_COUNT, 32'd0, 1'b0, "t8_cnt_p0");
    rd(A_COUNT, 32'd0, 1'b0, "t8_int_p0");
    rd(A_CTRL,  32'h8, 1'b1, "t8_irq_p0");
`else
    // Prescaled count steps every PRESCALE=4 cycles
    do_reset();
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'h9);
    idle();
    idle();
    for (int i = 0; i < 8; i++) begin
      rd(A_COUNT, (i < 4) ? 32'd2 : 32'd1, 1'b0, $sformatf("t6_prescale_%0d", i));
    end
    rd(A_COUNT, 32'd0, 1'b0, "t6_int");
    rd(A_COUNT, 32'd0, 1'b1, "t6_irq");
`endif

    mon_v = 1'b0;
    idle();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
